// File: rtl/gpio_in_conditioner.sv
// Per-pin GPIO input conditioning: multi-stage synchronizer, then either a
// bypass path or a consecutive-sample debouncer, plus registered edge pulses.
// Everything runs on HCLK and every output comes straight from a flop.
module gpio_in_conditioner #(
  parameter int unsigned          PORTWIDTH       = 16,
  parameter int unsigned          SYNC_STAGES     = 2,
  parameter int unsigned          DEBOUNCE_CYCLES = 16,
  parameter logic [PORTWIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [PORTWIDTH-1:0] PAD_IN,
  input  logic [PORTWIDTH-1:0] DB_EN,
  output logic [PORTWIDTH-1:0] PORTIN,
  output logic [PORTWIDTH-1:0] EDGE_RISE,
  output logic [PORTWIDTH-1:0] EDGE_FALL
);

  localparam int unsigned     CntW    = $clog2(DEBOUNCE_CYCLES + 1);
  // Count value at which the next mismatching sample is the accepting one.
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  // sync_q[0] captures the pad; sync_q[SYNC_STAGES-1] is the synchronized level.
  logic [SYNC_STAGES-1:0][PORTWIDTH-1:0] sync_q;
  logic [PORTWIDTH-1:0]                  sync_out;
  logic [PORTWIDTH-1:0]                  stable_q, stable_d;
  logic [PORTWIDTH-1:0]                  rise_q, fall_q;
  logic [PORTWIDTH-1:0][CntW-1:0]        cnt_q, cnt_d;

  // Synchronizer chain: plain shift register with async reset only.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sync_q <= {SYNC_STAGES{RESET_VALUE}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], PAD_IN};
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Next conditioned level and debounce count per pin; count defaults to clear.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    for (int unsigned i = 0; i < PORTWIDTH; i++) begin
      if (!DB_EN[i]) begin
        stable_d[i] = sync_out[i];
      end else if (sync_out[i] != stable_q[i]) begin
        if (cnt_q[i] == CntLast) begin
          stable_d[i] = sync_out[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  // Conditioned level, counters and edge pulses; pulses line up with the level change.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      stable_q <= RESET_VALUE;
      cnt_q    <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= stable_d & ~stable_q;
      fall_q   <= ~stable_d & stable_q;
    end
  end

  assign PORTIN    = stable_q;
  assign EDGE_RISE = rise_q;
  assign EDGE_FALL = fall_q;

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Self-checking bench for gpio_in_conditioner with default parameters.
module tb_gpio_in_conditioner;

  localparam int W    = 16;
  localparam int SYNC = 2;
  localparam int DB   = 16;

  logic         HCLK = 1'b0;
  logic         HRESETn;
  logic [W-1:0] PAD_IN;
  logic [W-1:0] DB_EN;
  logic [W-1:0] PORTIN;
  logic [W-1:0] EDGE_RISE;
  logic [W-1:0] EDGE_FALL;

  int checks = 0;
  int errors = 0;

  gpio_in_conditioner #(
    .PORTWIDTH      (W),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DB),
    .RESET_VALUE    ('0)
  ) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .PAD_IN   (PAD_IN),
    .DB_EN    (DB_EN),
    .PORTIN   (PORTIN),
    .EDGE_RISE(EDGE_RISE),
    .EDGE_FALL(EDGE_FALL)
  );

  always #5 HCLK = ~HCLK;

  // Reference model: pad history queue (newest first), accepted level and,
  // per pin, how many consecutive edges have seen a differing level.
  logic [W-1:0] hist[$];
  logic [W-1:0] m_lvl, m_rise, m_fall;
  int           streak[W];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < SYNC; k++) hist.push_front('0);
    m_lvl  = '0;
    m_rise = '0;
    m_fall = '0;
    for (int i = 0; i < W; i++) streak[i] = 0;
  endtask

  // Called right at a rising edge, while PAD_IN/DB_EN still hold pre-edge values.
  task automatic model_edge();
    logic [W-1:0] s, nl;
    s  = hist[SYNC-1];
    nl = m_lvl;
    for (int i = 0; i < W; i++) begin
      if (!DB_EN[i]) begin
        nl[i]     = s[i];
        streak[i] = 0;
      end else if (s[i] == m_lvl[i]) begin
        streak[i] = 0;
      end else begin
        streak[i] = streak[i] + 1;
        if (streak[i] == DB) begin
          nl[i]     = s[i];
          streak[i] = 0;
        end
      end
    end
    m_rise = nl & ~m_lvl;
    m_fall = ~nl & m_lvl;
    m_lvl  = nl;
    hist.push_front(PAD_IN);
    void'(hist.pop_back());
  endtask

  task automatic step();
    @(posedge HCLK);
    model_edge();
    #1;
    chk("portin", 32'(PORTIN), 32'(m_lvl));
    chk("edge_rise", 32'(EDGE_RISE), 32'(m_rise));
    chk("edge_fall", 32'(EDGE_FALL), 32'(m_fall));
  endtask

  task automatic reset_step();
    @(posedge HCLK);
    #1;
    chk("rst_portin", 32'(PORTIN), 32'h0);
    chk("rst_rise", 32'(EDGE_RISE), 32'h0);
    chk("rst_fall", 32'(EDGE_FALL), 32'h0);
  endtask

  // Steps until PORTIN[pin] reaches val (bounded); n is the edge count taken.
  task automatic wait_bit(input int pin, input logic val, input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (PORTIN[pin] !== val && n < limit);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic rose;
    logic [W-1:0] p;

    // Reset held: pads toggle, outputs stay at reset value.
    HRESETn = 1'b0;
    DB_EN   = '0;
    PAD_IN  = W'($urandom);
    for (int k = 0; k < 4; k++) begin
      reset_step();
      PAD_IN = W'($urandom);
    end
    PAD_IN = '0;
    model_reset();
    reset_step();
    HRESETn = 1'b1;
    for (int k = 0; k < 4; k++) step();

    // Bypass latency on pin 3, rise then fall.
    PAD_IN[3] = 1'b1;
    wait_bit(3, 1'b1, 10, n);
    chk("bypass_rise_lat", 32'(n), 32'd3);
    chk("bypass_rise_pulse", 32'(EDGE_RISE[3]), 32'd1);
    step();
    chk("bypass_rise_once", 32'(EDGE_RISE[3]), 32'd0);
    PAD_IN[3] = 1'b0;
    wait_bit(3, 1'b0, 10, n);
    chk("bypass_fall_lat", 32'(n), 32'd3);
    chk("bypass_fall_pulse", 32'(EDGE_FALL[3]), 32'd1);
    for (int k = 0; k < 3; k++) step();

    // Debounce accept on pin 0 at exactly SYNC+DB edges.
    DB_EN     = '1;
    step();
    PAD_IN[0] = 1'b1;
    wait_bit(0, 1'b1, 40, n);
    chk("db_accept_lat", 32'(n), 32'(SYNC + DB));
    chk("db_accept_pulse", 32'(EDGE_RISE[0]), 32'd1);
    step();

    // A 15-cycle pulse on pin 5 alone never reaches PORTIN.
    PAD_IN[5] = 1'b1;
    rose = 1'b0;
    for (int k = 0; k < DB - 1; k++) begin
      step();
      rose |= PORTIN[5];
    end
    PAD_IN[5] = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step();
      rose |= PORTIN[5];
    end
    chk("glitch15_reject", 32'(rose), 32'd0);

    // 15 high, 1 low glitch, then held high: full count restarts after the glitch.
    PAD_IN[5] = 1'b1;
    for (int k = 0; k < DB - 1; k++) step();
    PAD_IN[5] = 1'b0;
    step();
    PAD_IN[5] = 1'b1;
    wait_bit(5, 1'b1, 40, n);
    chk("glitch_restart_lat", 32'(n), 32'(SYNC + DB));

    // Mode switch on pin 2 with the count at 10.
    PAD_IN[2] = 1'b1;
    for (int k = 0; k < 12; k++) step();
    chk("modesw_hold", 32'(PORTIN[2]), 32'd0);
    DB_EN[2] = 1'b0;
    step();
    chk("modesw_follow", 32'(PORTIN[2]), 32'd1);
    chk("modesw_pulse", 32'(EDGE_RISE[2]), 32'd1);
    DB_EN[2]  = 1'b1;
    PAD_IN[2] = 1'b0;
    wait_bit(2, 1'b0, 40, n);
    chk("modesw_recount", 32'(n), 32'(SYNC + DB));

    // Async reset mid-count while a rise pulse is high.
    DB_EN     = 16'hFFFD;
    PAD_IN[1] = 1'b1;
    PAD_IN[7] = 1'b1;
    for (int k = 0; k < 3; k++) step();
    chk("pre_rst_pulse", 32'(EDGE_RISE[1]), 32'd1);
    chk("pre_rst_level", 32'(PORTIN != 0), 32'd1);
    #2;
    HRESETn = 1'b0;
    #1;
    chk("async_portin", 32'(PORTIN), 32'h0);
    chk("async_rise", 32'(EDGE_RISE), 32'h0);
    chk("async_fall", 32'(EDGE_FALL), 32'h0);
    PAD_IN = '0;
    model_reset();
    reset_step();
    reset_step();
    HRESETn = 1'b1;
    for (int k = 0; k < 4; k++) step();

    // Staggered changes on all pins, mixed bypass/debounce.
    DB_EN = W'($urandom);
    for (int t = 0; t < 2 * W + 40; t++) begin
      p = PAD_IN;
      for (int i = 0; i < W; i++) if (t == 2 * i) p[i] = ~p[i];
      PAD_IN = p;
      step();
    end

    // Random pad activity with occasional mode changes.
    for (int t = 0; t < 1500; t++) begin
      if (t % 250 == 0) DB_EN = W'($urandom);
      p = PAD_IN;
      for (int i = 0; i < W; i++) if ($urandom_range(23) == 0) p[i] = ~p[i];
      PAD_IN = p;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_in_conditioner.md
# gpio_in_conditioner

Per-pin input conditioning stage between the GPIO pads and the `PORTIN` input of the AHB GPIO block. Each pin is first passed through a multi-stage synchronizer. It then goes through either a bypass path or a counter-based debouncer, selected per pin. The stage also produces single-cycle rising and falling edge pulses aligned to the conditioned output. It runs entirely in the GPIO bus clock domain, so `PORTIN` reaches the GPIO block already synchronous and glitch-filtered.

## Interface
- `PORTWIDTH`, 16: number of pins.
- `SYNC_STAGES`, 2: synchronizer depth. Legal range is 2..4.
- `DEBOUNCE_CYCLES`, 16: number of consecutive mismatching synchronized samples needed to accept a new level. Must be ≥1.
- `RESET_VALUE`, all-zero `PORTWIDTH`-bit vector: reset value of the synchronizer flops and the conditioned output.

- `HCLK`, in, 1: system bus clock. The only clock.
- `HRESETn`, in, 1: reset, asynchronous assert, active-low.
- `PAD_IN`, in, `PORTWIDTH`: raw asynchronous pad inputs.
- `DB_EN`, in, `PORTWIDTH`: per-pin debounce enable. 1 = debounce, 0 = bypass. Quasi-static.
- `PORTIN`, out, `PORTWIDTH`: conditioned level; connects to the GPIO block's `PORTIN`.
- `EDGE_RISE`, out, `PORTWIDTH`: one-cycle pulse when `PORTIN[i]` goes 0→1.
- `EDGE_FALL`, out, `PORTWIDTH`: one-cycle pulse when `PORTIN[i]` goes 1→0.

## Operation
Per-pin state:
- `SYNC_STAGES` synchronizer flops. The last flop is `s[i]`.
- A stable register, driven directly onto `PORTIN[i]`.
- A counter `cnt[i]` of width `$clog2(DEBOUNCE_CYCLES+1)`.

Reset (`HRESETn` low, asynchronous):
- Synchronizer flops and `PORTIN` take `RESET_VALUE`.
- `cnt` = 0.
- `EDGE_RISE` = `EDGE_FALL` = 0.
- No edge pulse is generated on reset release.

Every `HCLK` rising edge, per pin:
- **Bypass** (`DB_EN[i]`=0): `PORTIN[i]` ← `s[i]`; `cnt[i]` ← 0.
- **Debounce, match** (`DB_EN[i]`=1, `s[i]` == `PORTIN[i]`): `cnt[i]` ← 0.
- **Debounce, mismatch, count not reached** (`s[i]` ≠ `PORTIN[i]`, `cnt[i]` < `DEBOUNCE_CYCLES`−1): `cnt[i]` ← `cnt[i]`+1.
- **Debounce, mismatch, count reached** (`s[i]` ≠ `PORTIN[i]`, `cnt[i]` == `DEBOUNCE_CYCLES`−1): `PORTIN[i]` ← `s[i]`; `cnt[i]` ← 0.

Edge pulses:
- `EDGE_RISE[i]` ← `next_PORTIN[i]` & ~`PORTIN[i]`.
- `EDGE_FALL[i]` ← ~`next_PORTIN[i]` & `PORTIN[i]`.
- Both are registered, so a pulse is high in exactly the first cycle `PORTIN` shows the new value.

Boundary rules:
- A glitch shorter than `DEBOUNCE_CYCLES` synchronized cycles clears the count and never changes `PORTIN`.
- The count is consecutive-only. Any matching sample restarts it from 0.
- The counter never exceeds `DEBOUNCE_CYCLES`−1. No wrap is possible.
- `DB_EN` 1→0 mid-count: the next edge takes bypass behaviour and the count is discarded.
- `DB_EN` 0→1: the count starts from 0 at that edge.
- `DEBOUNCE_CYCLES`=1 is behaviourally identical to bypass.
- Pins are fully independent. Simultaneous changes on several pins produce simultaneous, independent pulses.
- `EDGE_RISE[i]` and `EDGE_FALL[i]` are never both 1.
- Reset asserted mid-count returns everything to reset values immediately, without waiting for a clock.

## Timing
Latency is counted from the first `HCLK` edge that samples a new `PAD_IN` value, with the input held stable.
- Bypass: `PORTIN` changes at edge `SYNC_STAGES`+1. With defaults, edge 3.
- Debounce: `PORTIN` changes at edge `SYNC_STAGES`+`DEBOUNCE_CYCLES`. With defaults, edge 18.
- Edge pulses coincide with the `PORTIN` change and last exactly 1 cycle.
- Synchronizer flops carry no reset-dependent logic beyond the async reset, and there is no combinational path from `PAD_IN` to any output.
- Outputs are pure flop outputs. The GPIO block samples them directly on `HCLK`.

## Test plan
- **Reset:** hold `HRESETn`=0, toggle `PAD_IN` → `PORTIN`=`RESET_VALUE` and edge outputs = 0. After release with `PAD_IN`=`RESET_VALUE` → no pulse.
- **Bypass latency:** `DB_EN`=0, `PAD_IN[3]` 0→1 → `PORTIN[3]`=1 at edge 3 and `EDGE_RISE[3]`=1 for that single cycle. Return to 0 → `EDGE_FALL[3]` pulses, also 3 edges later.
- **Debounce accept:** `DB_EN`=FFFF, `PAD_IN[0]` 0→1 held → `PORTIN[0]` rises at edge 18 exactly, with a 1-cycle `EDGE_RISE[0]`. Nothing changes at edge 17.
- **Glitch reject:** `PAD_IN[5]` high for 15 cycles, low for 1, high again → no change until 16 consecutive high samples after the glitch. A 15-cycle pulse alone never appears on `PORTIN`.
- **Mode switch mid-count:** debounce count at 10, then drop `DB_EN[2]` → `PORTIN[2]` follows `s[2]` at the next edge, and the count is cleared.
- **Async reset mid-count, plus pin independence:**
  - Assert `HRESETn` between clocks during a count → outputs return to reset values before the next edge.
  - After reset, drive all 16 pins with staggered changes → each pin meets its own latency with no cross-pin interaction.
